// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: 16-bit little-endian word count header, then payload words.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int REG_NUM    = (2**ADDR_WIDTH)/4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wen,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-2:0] word_cnt
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE, ERR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-2:0] word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wen_q, wen_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cpu_rst_n_q, cpu_rst_n_d;
  logic                  accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  assign rx_ready = !(state_q inside {IDLE, DONE, ERR});
  assign accept   = rx_valid && rx_ready;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    asm_d      = asm_q;
    idx_d      = idx_q;
    word_cnt_d = word_cnt_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wen_d      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = HDR0;
          word_cnt_d = '0;
          idx_d      = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      HDR0: begin
        if (accept) begin
          count_d[7:0] = rx_data;
          state_d      = HDR1;
        end
      end
      HDR1: begin
        if (accept) begin
          count_d[15:8] = rx_data;
          if ({rx_data, count_q[7:0]} == 16'd0)
            state_d = DONE;
          else if (32'({rx_data, count_q[7:0]}) > 32'(REG_NUM))
            state_d = ERR;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          asm_d[int'(idx_q)*8 +: 8] = rx_data;
          if (32'(idx_q) == BPW - 1) begin
            // Word complete: strobe the write and advance the word counter together
            idx_d      = '0;
            wen_d      = 1'b1;
            wdata_d    = asm_d;
            waddr_d    = {word_cnt_q[ADDR_WIDTH-3:0], 2'b00};
            word_cnt_d = word_cnt_q + 1'b1;
            if (32'(word_cnt_q) + 1 == 32'(count_q)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = CSUM;
`else
              state_d = DONE;
`endif
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) state_d = (rx_data == csum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Status flags follow the next state so the registered copies line up with state_q
    busy_d      = !(state_d inside {IDLE, DONE, ERR});
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERR);
    cpu_rst_n_d = (state_d == IDLE) || (state_d == DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      asm_q       <= '0;
      idx_q       <= '0;
      word_cnt_q  <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      asm_q       <= asm_d;
      idx_q       <= idx_d;
      word_cnt_q  <= word_cnt_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_rst_n_q <= cpu_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign wen       = wen_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader; sessions are stream records with expected outcomes.
module tb_imem_loader;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [12:0] waddr;
  logic [31:0] wdata;
  logic        wen;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [11:0] word_cnt;

  imem_loader dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .waddr(waddr), .wdata(wdata),
    .wen(wen), .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done),
    .error(error), .word_cnt(word_cnt)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bad_wen = 0;
  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];
  int          wc_log[$];

  always @(posedge i_clk) cyc++;

  always @(negedge i_clk) begin
    if (wen) begin
      wa_log.push_back(32'(waddr));
      wd_log.push_back(wdata);
      wc_log.push_back(cyc);
      if (error) bad_wen++;
    end
  end

  typedef struct {
    logic [127:0] bytes;
    int           n;
    logic [7:0]   trailer;
    bit           use_tr;
    bit           stall;
    int           exp_nw;
    logic [31:0]  w0;
    logic [31:0]  w1;
    bit           exp_done;
    bit           exp_err;
    int           exp_wc;
  } vec_t;

  vec_t tv[8];
  int   nv = 0;
  int   base = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic [127:0] b, input int n, input logic [7:0] tr, input bit use_tr,
                     input bit stall, input int nw, input logic [31:0] w0, input logic [31:0] w1,
                     input bit d, input bit e, input int wc);
    tv[nv].bytes = b; tv[nv].n = n; tv[nv].trailer = tr; tv[nv].use_tr = use_tr;
    tv[nv].stall = stall; tv[nv].exp_nw = nw; tv[nv].w0 = w0; tv[nv].w1 = w1;
    tv[nv].exp_done = d; tv[nv].exp_err = e; tv[nv].exp_wc = wc;
    nv++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stalls);
    int  guard;
    bit  ok;
    for (int s = 0; s < stalls; s++) begin
      rx_valid = 1'b0;
      @(negedge i_clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    guard    = 0;
    do begin
      ok = rx_ready;
      @(negedge i_clk);
      guard++;
    end while (!ok && guard < 50);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout actual=%h required=accepted", b);
    end
  endtask

  task automatic run_session(input int i, input int nbytes);
    base = wa_log.size();
    @(negedge i_clk);
    start = 1'b1;
    @(negedge i_clk);
    start = 1'b0;
    for (int k = 0; k < nbytes; k++) begin
      if (tv[i].stall && k == 5) start = 1'b1;
      send_byte(tv[i].bytes[k*8 +: 8], tv[i].stall ? int'($urandom_range(0, 2)) : 0);
      start = 1'b0;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (tv[i].use_tr && nbytes == tv[i].n) send_byte(tv[i].trailer, 0);
`endif
    rx_valid = 1'b0;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic check_session(input int i);
    string p;
    p = $sformatf("v%0d_", i);
    chk({p, "nwrites"}, 32'(wa_log.size() - base), 32'(tv[i].exp_nw));
    if (wa_log.size() - base == tv[i].exp_nw) begin
      for (int j = 0; j < tv[i].exp_nw; j++) begin
        chk($sformatf("%swaddr%0d", p, j), wa_log[base+j], 32'(j*4));
        chk($sformatf("%swdata%0d", p, j), wd_log[base+j], (j == 0) ? tv[i].w0 : tv[i].w1);
      end
      if (tv[i].exp_nw == 2 && !tv[i].stall)
        chk({p, "throughput"}, 32'(wc_log[base+1] - wc_log[base]), 32'd4);
      if (tv[i].exp_nw > 0)
        chk({p, "waddr_hold"}, 32'(waddr), 32'((tv[i].exp_nw - 1) * 4));
    end
    chk({p, "done"}, 32'(done), 32'(tv[i].exp_done));
    chk({p, "error"}, 32'(error), 32'(tv[i].exp_err));
    chk({p, "cpu_rst_n"}, 32'(cpu_rst_n), 32'(!tv[i].exp_err));
    chk({p, "busy"}, 32'(busy), 32'd0);
    chk({p, "word_cnt"}, 32'(word_cnt), 32'(tv[i].exp_wc));
  endtask

  task automatic check_all_zero(input string p);
    chk({p, "wen"}, 32'(wen), 32'd0);
    chk({p, "waddr"}, 32'(waddr), 32'd0);
    chk({p, "wdata"}, wdata, 32'd0);
    chk({p, "word_cnt"}, 32'(word_cnt), 32'd0);
    chk({p, "busy"}, 32'(busy), 32'd0);
    chk({p, "done"}, 32'(done), 32'd0);
    chk({p, "error"}, 32'(error), 32'd0);
    chk({p, "cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    chk({p, "rx_ready"}, 32'(rx_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // stream 02 00 78 56 34 12 EF BE AD DE, packed little-endian
    add(128'hDEADBEEF_12345678_0002, 10, 8'h2A, 1, 0, 2, 32'h12345678, 32'hDEADBEEF, 1, 0, 2);
    add(128'hDEADBEEF_12345678_0002, 10, 8'h2A, 1, 1, 2, 32'h12345678, 32'hDEADBEEF, 1, 0, 2);
    add(128'h0801, 2, 8'h00, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0);
    add(128'hDEADBEEF_12345678_0002, 10, 8'h2A, 1, 0, 2, 32'h12345678, 32'hDEADBEEF, 1, 0, 2);
    add(128'h0000, 2, 8'h00, 0, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    add(128'h44332211_0001, 6, 8'h44, 1, 0, 1, 32'h44332211, 32'h0, 1, 0, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    add(128'hDEADBEEF_12345678_0002, 10, 8'h2B, 1, 0, 2, 32'h12345678, 32'hDEADBEEF, 0, 1, 2);
    add(128'hDEADBEEF_12345678_0002, 10, 8'h2A, 1, 0, 2, 32'h12345678, 32'hDEADBEEF, 1, 0, 2);
`endif

    repeat (3) @(negedge i_clk);
    check_all_zero("rst_");
    i_rst_n = 1'b1;
    #1;
    chk("rel_cpu_rst_n_before_edge", 32'(cpu_rst_n), 32'd0);
    @(negedge i_clk);
    chk("rel_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);

    for (int i = 0; i < nv; i++) begin
      run_session(i, tv[i].n);
      check_session(i);
    end

    // Reset mid-DATA after one and a half words, then a fresh session
    run_session(0, 0);
    for (int k = 0; k < 8; k++) send_byte(tv[0].bytes[k*8 +: 8], 0);
    i_rst_n = 1'b0;
    #1;
    check_all_zero("midrst_");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("midrst_cpu_rst_n_after", 32'(cpu_rst_n), 32'd1);
    run_session(0, tv[0].n);
    check_session(0);

    chk("no_wen_in_err", 32'(bad_wen), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the instruction word width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 13, giving the byte-address width of the instruction memory write port.
REQ-003 The module SHALL have parameter REG_NUM, default (2**ADDR_WIDTH)/4, giving the memory capacity in words.
REQ-004 The module SHALL have the following ports, one per line as name, direction, width, meaning:
  i_clk  in  1  single clock; all logic is on the rising edge
  i_rst_n  in  1  reset, asynchronous, active-low
  start  in  1  pulse that begins a load session
  rx_data  in  8  incoming byte stream
  rx_valid  in  1  rx_data is valid
  rx_ready  out  1  loader accepts a byte; a transfer occurs when rx_valid && rx_ready on a clock edge
  waddr  out  ADDR_WIDTH  byte address of the write, always word-aligned
  wdata  out  DATA_WIDTH  assembled instruction word
  wen  out  1  single-cycle write strobe to the instruction memory
  cpu_rst_n  out  1  active-low hold for the pipeline; low while loading or after an error
  busy  out  1  load session in progress
  done  out  1  last session completed without error
  error  out  1  last session aborted
  word_cnt  out  ADDR_WIDTH-1  number of words written in the current session

Function
REQ-005 The FSM SHALL have the states IDLE, HDR0, HDR1, DATA, CSUM, DONE and ERR; CSUM exists only with the macro defined.
REQ-006 IDLE or DONE or ERR with start=1 SHALL go to HDR0 on the next edge, clearing word_cnt, the byte index, done and error.
REQ-007 start SHALL be ignored in HDR0, HDR1, DATA and CSUM.
REQ-008 rx_ready SHALL be 1 in HDR0, HDR1, DATA and CSUM, and 0 in all other states; a byte presented in IDLE is never consumed.
REQ-009 HDR0 SHALL capture the accepted byte as count[7:0], then go to HDR1.
REQ-010 HDR1 SHALL capture the accepted byte as count[15:8], then branch on count:
  - count==0: go to DONE.
  - count>REG_NUM: go to ERR.
  - otherwise: go to DATA.
REQ-011 DATA SHALL assemble bytes little-endian: the first accepted byte goes to [7:0] and the fourth to [31:24].
REQ-012 After the fourth byte of a word is accepted, the loader SHALL assert wen for exactly the next cycle, with wdata equal to the assembled word and waddr equal to word_cnt*4; word_cnt increments in that same cycle.
REQ-013 waddr and wdata SHALL hold their values between writes.
REQ-014 Cycles with rx_valid=0 SHALL stall assembly without losing partial bytes.
REQ-015 At full throughput (rx_valid held high) the loader SHALL write one word every 4 cycles.
REQ-016 After the write of word number count, the FSM SHALL go to CSUM if the macro is defined, otherwise to DONE.
REQ-017 In DONE, done SHALL be 1 and cpu_rst_n SHALL be 1.
REQ-018 In ERR, error SHALL be 1, cpu_rst_n SHALL be 0 and wen SHALL never assert.
REQ-019 In IDLE, cpu_rst_n SHALL be 1.
REQ-020 busy SHALL be 1 exactly in HDR0, HDR1, DATA and CSUM, and cpu_rst_n SHALL be 0 in those states.
REQ-021 All outputs SHALL be registered, except rx_ready, which decodes directly from the state.

Reset
REQ-022 Asserting i_rst_n low SHALL immediately force the state to IDLE, and SHALL force wen, waddr, wdata, word_cnt, busy, done, error and cpu_rst_n to 0.
REQ-023 After i_rst_n is released, cpu_rst_n SHALL rise on the first clock edge.
REQ-024 A reset during a session SHALL abandon that session; memory words already written stay written.

Configuration
REQ-025 With IMEM_LOADER_CHECKSUM_EN defined, the loader SHALL keep an 8-bit XOR of all payload bytes (header excluded) and SHALL read one more byte in CSUM: equal goes to DONE, unequal goes to ERR.
REQ-026 Without IMEM_LOADER_CHECKSUM_EN, the loader SHALL have no CSUM state and no checksum logic, and SHALL read no trailing byte.

Verification
REQ-027 Reset: hold i_rst_n=0 -> all outputs 0; release -> cpu_rst_n=1 one edge later, busy=0.
REQ-028 Basic load: start, then bytes 02 00 78 56 34 12 EF BE AD DE (plus 2A with the macro) -> wen @waddr 0x000 wdata 0x12345678, wen @0x004 wdata 0xDEADBEEF, word_cnt=2, done=1, cpu_rst_n=1.
REQ-029 Backpressure: same stream as REQ-028 with rx_valid randomly deasserted, and start pulsed mid-DATA -> identical writes, start ignored.
REQ-030 Oversize header: bytes 01 08 (count 2049) -> error=1, no wen, cpu_rst_n=0; a later start with a valid stream recovers to done=1.
REQ-031 Checksum (macro defined): the REQ-028 stream with trailer 2B -> error=1 after 2 writes; with trailer 2A -> done=1.
REQ-032 Async reset mid-DATA after 1.5 words -> outputs 0 immediately, state IDLE, and a new session restarts at waddr 0x000.
